// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter:
// grant state encoding, cycle-type constants and bus widths.
package wb_rr_arbiter_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts strobe cycles without a slave response and flags expiry
// on the TIMEOUT-th such cycle. Also used by the conbus slave-timeout path.
module wb_watchdog #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_stb,
  input  logic i_resp,
  output logic o_expire
);

  localparam logic [TO_W-1:0] LP_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;
  logic            w_clear;

  // A response in the expiry cycle takes priority, so the access completes normally.
  assign o_expire = i_en & i_stb & ~i_resp & ~i_rst & (r_cnt == LP_LAST);
  assign w_clear  = ~i_en | ~i_stb | i_resp | o_expire;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_clear) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master to one-slave Wishbone B3 arbiter. Round-robin grant held for the
// whole CYC span, combinational slave mux, and a watchdog that errors stuck accesses.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic [2:0]       m0_cti_i,
  input  logic [1:0]       m0_bte_i,
  input  logic             m0_lock_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic             m0_rty_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic [2:0]       m1_cti_i,
  input  logic [1:0]       m1_bte_i,
  input  logic             m1_lock_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             m1_rty_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic [DAT_W-1:0] s_dat_i,
  output logic [SEL_W-1:0] s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic [2:0]       s_cti_o,
  output logic [1:0]       s_bte_o,
  output logic             s_lock_o,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic             s_rty_i,
  output logic [1:0]       gnt_o,
  output logic             timeout_o
);

  arb_state_t r_state, w_state_nxt;
  logic       r_last, w_last_nxt;
  logic       w_own0, w_own1, w_own_cyc, w_own_stb, w_resp, w_expire;

  assign w_own0 = (r_state == ST_OWN0);
  assign w_own1 = (r_state == ST_OWN1);
  assign w_resp = s_ack_i | s_err_i | s_rty_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Handover goes straight to the waiting master, so there is no idle cycle between owners.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
        else if (m0_cyc_i)        w_state_nxt = ST_OWN0;
        else if (m1_cyc_i)        w_state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          w_last_nxt  = 1'b0;
          w_state_nxt = m1_cyc_i ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          w_last_nxt  = 1'b1;
          w_state_nxt = m0_cyc_i ? ST_OWN0 : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    s_lock_o  = 1'b0;
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    if (w_own0) begin
      s_adr_o   = m0_adr_i;
      s_dat_o   = m0_dat_i;
      s_sel_o   = m0_sel_i;
      s_we_o    = m0_we_i;
      s_cti_o   = m0_cti_i;
      s_bte_o   = m0_bte_i;
      s_lock_o  = m0_lock_i;
      w_own_cyc = m0_cyc_i;
      w_own_stb = m0_stb_i;
    end else if (w_own1) begin
      s_adr_o   = m1_adr_i;
      s_dat_o   = m1_dat_i;
      s_sel_o   = m1_sel_i;
      s_we_o    = m1_we_i;
      s_cti_o   = m1_cti_i;
      s_bte_o   = m1_bte_i;
      s_lock_o  = m1_lock_i;
      w_own_cyc = m1_cyc_i;
      w_own_stb = m1_stb_i;
    end
  end

  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_en     (w_own0 | w_own1),
    .i_stb    (w_own_stb),
    .i_resp   (w_resp),
    .o_expire (w_expire)
  );

  assign s_cyc_o   = w_own_cyc;
  assign s_stb_o   = w_own_stb & ~w_expire;
  assign gnt_o     = {w_own1, w_own0};
  assign timeout_o = w_expire;

  // Responses are blocked during reset so an in-flight beat is never completed.
  assign m0_ack_o = w_own0 & ~rst_i & s_ack_i;
  assign m0_err_o = w_own0 & ~rst_i & (s_err_i | w_expire);
  assign m0_rty_o = w_own0 & ~rst_i & s_rty_i;
  assign m1_ack_o = w_own1 & ~rst_i & s_ack_i;
  assign m1_err_o = w_own1 & ~rst_i & (s_err_i | w_expire);
  assign m1_rty_o = w_own1 & ~rst_i & s_rty_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed master/slave traffic, a cycle-level grant
// model checked every negedge, and literal expectations for key scenarios.
module tb_wb_rr_arbiter;
  import wb_rr_arbiter_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  cyc, stb, we, lock;
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [3:0]  sel  [2];
  logic [2:0]  cti  [2];
  logic [1:0]  bte  [2];
  wire  [31:0] mdat [2];
  wire  [1:0]  ack_o, err_o, rty_o;

  logic [31:0] s_dat_i = 32'hD000_0000;
  logic        s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
  wire  [31:0] s_adr_o, s_dat_o;
  wire  [3:0]  s_sel_o;
  wire         s_we_o, s_cyc_o, s_stb_o, s_lock_o, timeout_o;
  wire  [2:0]  s_cti_o;
  wire  [1:0]  s_bte_o, gnt_o;

  wb_rr_arbiter #(.TIMEOUT(TO), .TO_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(mdat[0]), .m0_sel_i(sel[0]),
    .m0_we_i(we[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_cti_i(cti[0]),
    .m0_bte_i(bte[0]), .m0_lock_i(lock[0]),
    .m0_ack_o(ack_o[0]), .m0_err_o(err_o[0]), .m0_rty_o(rty_o[0]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(mdat[1]), .m1_sel_i(sel[1]),
    .m1_we_i(we[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_cti_i(cti[1]),
    .m1_bte_i(bte[1]), .m1_lock_i(lock[1]),
    .m1_ack_o(ack_o[1]), .m1_err_o(err_o[1]), .m1_rty_o(rty_o[1]),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o),
    .s_bte_o(s_bte_o), .s_lock_o(s_lock_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: responds one cycle after it first sees a strobe, then idles one cycle.
  logic slv_en = 1'b0, force_ack = 1'b0, slv_req = 1'b0;
  int   slv_kind = 0;
  always @(negedge clk)
    slv_req = slv_en && s_cyc_o && s_stb_o && !(s_ack_i || s_err_i || s_rty_i);
  always @(posedge clk) begin
    #1;
    s_ack_i = (slv_req && slv_kind == 0) || force_ack;
    s_err_i = slv_req && slv_kind == 1;
    s_rty_i = slv_req && slv_kind == 2;
    s_dat_i = s_dat_i + 32'h0001_0003;
  end

  // Reference model: owner (0 none, 1 m0, 2 m1), last finished master, unanswered strobe count.
  int   m_own = 0, m_last = 1, m_wd = 0;
  bit   m_valid = 1'b0;
  bit   rec_en = 1'b0;
  int   gseq[$];
  int   ack_cnt[2] = '{0, 0};
  logic [1:0] prev_gnt = 2'b00;

  always @(negedge clk) begin : model
    logic       act, ostb, ocyc, resp, eto, fwd;
    int         ox;
    logic [1:0] eg;
    logic [5:0] er;
    act  = (m_own != 0);
    ox   = act ? m_own - 1 : 0;
    ocyc = act && cyc[ox];
    ostb = act && stb[ox];
    resp = s_ack_i || s_err_i || s_rty_i;
    eto  = ostb && !resp && !rst && (m_wd == TO - 1);
    if (m_valid) begin
      eg = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
      check("gnt", gnt_o, eg);
      check("s_ctl", {s_cyc_o, s_stb_o}, {ocyc, ostb && !eto});
      check("timeout", timeout_o, eto);
      er = '0;
      for (int i = 0; i < 2; i++) begin
        fwd = act && (ox == i) && !rst;
        er[3*i +: 3] = {fwd && s_ack_i, fwd && (s_err_i || eto), fwd && s_rty_i};
      end
      check("m_resp", {ack_o[1], err_o[1], rty_o[1], ack_o[0], err_o[0], rty_o[0]}, er);
      check("m_dat", {mdat[1], mdat[0]}, {s_dat_i, s_dat_i});
      if (act) begin
        check("s_path", {s_adr_o, s_dat_o}, {adr[ox], wdat[ox]});
        check("s_attr", {s_sel_o, s_we_o, s_cti_o, s_bte_o, s_lock_o},
              {sel[ox], we[ox], cti[ox], bte[ox], lock[ox]});
      end
      if (rec_en && gnt_o != prev_gnt && gnt_o != 2'b00) gseq.push_back(gnt_o == 2'b01 ? 0 : 1);
      prev_gnt = gnt_o;
      for (int i = 0; i < 2; i++) if (ack_o[i]) ack_cnt[i]++;
    end
    if (rst) begin
      m_own = 0; m_last = 1; m_wd = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (act && ostb && !resp && !eto) m_wd++;
      else m_wd = 0;
      if (!act) begin
        if (cyc == 2'b11)  m_own = (m_last == 1) ? 1 : 2;
        else if (cyc[0])   m_own = 1;
        else if (cyc[1])   m_own = 2;
      end else if (!cyc[ox]) begin
        m_last = ox;
        m_own  = cyc[1-ox] ? (2 - ox) : 0;
      end
    end
  end

  task automatic raise(input int i, input logic [31:0] a, input logic w,
                       input logic [2:0] c, input logic l);
    @(posedge clk); #1;
    adr[i] = a; wdat[i] = a ^ 32'h5A5A_0000; we[i] = w; sel[i] = 4'hF;
    cti[i] = c; lock[i] = l; bte[i] = 2'b00; cyc[i] = 1'b1; stb[i] = 1'b1;
  endtask

  task automatic drop(input int i);
    @(posedge clk); #1;
    cyc[i] = 1'b0; stb[i] = 1'b0; cti[i] = CTI_CLASSIC; lock[i] = 1'b0;
  endtask

  task automatic wait_resp(input int i, input int max, output logic [2:0] r);
    r = 3'b000;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (ack_o[i] || err_o[i] || rty_o[i]) begin
        r = {ack_o[i], err_o[i], rty_o[i]};
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL wait_resp m%0d: no response within %0d cycles", i, max);
  endtask

  task automatic single(input int i, input logic [31:0] a, output logic [2:0] r);
    raise(i, a, 1'b0, CTI_CLASSIC, 1'b0);
    wait_resp(i, 40, r);
    drop(i);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [2:0] r, r0, r1;
    int n0, n1, same, a0, a1, beats;
    cyc = '0; stb = '0; we = '0; lock = '0;
    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; wdat[i] = '0; sel[i] = '0; cti[i] = CTI_CLASSIC; bte[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_sctl", {s_cyc_o, s_stb_o, timeout_o}, 3'b000);
    check("rst_resp", {ack_o, err_o, rty_o}, 6'b0);
    @(posedge clk); #1; rst = 1'b0;

    // m1 classic read
    slv_en = 1'b1; slv_kind = 0;
    a0 = ack_cnt[0];
    raise(1, 32'h0000_0010, 1'b0, CTI_CLASSIC, 1'b0);
    @(negedge clk);
    check("lat_idle", {gnt_o, s_cyc_o}, 3'b000);
    @(negedge clk);
    check("lat_own", {gnt_o, s_cyc_o}, 3'b101);
    check("m1_adr", s_adr_o, 32'h0000_0010);
    wait_resp(1, 20, r);
    check("m1_ack", r, 3'b100);
    check("m1_dat", mdat[1], s_dat_i);
    drop(1);
    check("m0_no_ack", ack_cnt[0] - a0, 0);

    // error and retry forwarding
    slv_kind = 1; single(0, 32'h0000_0020, r); check("m0_err", r, 3'b010);
    slv_kind = 2; single(1, 32'h0000_0024, r); check("m1_rty", r, 3'b001);
    slv_kind = 0;

    // simultaneous request out of reset: m0 first, handover without idle
    do_reset();
    fork
      raise(0, 32'h0000_0030, 1'b0, CTI_CLASSIC, 1'b0);
      raise(1, 32'h0000_0034, 1'b1, CTI_CLASSIC, 1'b0);
    join
    @(negedge clk);
    @(negedge clk);
    check("tie_m0", gnt_o, 2'b01);
    wait_resp(0, 20, r);
    drop(0);
    @(negedge clk);
    check("hand_hold", gnt_o, 2'b01);
    @(negedge clk);
    check("hand_m1", gnt_o, 2'b10);
    wait_resp(1, 20, r);
    check("hand_m1_ack", r, 3'b100);
    drop(1);

    // round-robin fairness over 20 transactions
    gseq.delete();
    rec_en = 1'b1;
    fork
      for (int k = 0; k < 10; k++) single(0, 32'h0000_1000 + 32'(k * 4), r0);
      for (int k = 0; k < 10; k++) single(1, 32'h0000_2000 + 32'(k * 4), r1);
    join
    rec_en = 1'b0;
    n0 = 0; n1 = 0; same = 0;
    foreach (gseq[k]) begin
      if (gseq[k] == 0) n0++; else n1++;
      if (k > 0 && gseq[k] == gseq[k-1]) same++;
    end
    check("rr_n0", n0, 10);
    check("rr_n1", n1, 10);
    check("rr_alt", same, 0);
    if (gseq.size() > 0) check("rr_first", gseq[0], 0);

    // locked incrementing burst on m0 while m1 waits
    a0 = ack_cnt[0]; a1 = ack_cnt[1]; beats = 0;
    fork
      raise(0, 32'h0000_0100, 1'b0, CTI_INCR, 1'b1);
      raise(1, 32'h0000_0200, 1'b1, CTI_CLASSIC, 1'b0);
    join
    @(negedge clk);
    @(negedge clk);
    check("burst_gnt", gnt_o, 2'b01);
    for (int b = 0; b < 4; b++) begin
      wait_resp(0, 20, r);
      if (r == 3'b100) beats++;
      if (b < 3) begin
        @(posedge clk); #1;
        adr[0] = adr[0] + 32'd4;
        cti[0] = (b == 2) ? CTI_EOB : CTI_INCR;
      end
    end
    drop(0);
    check("burst_beats", beats, 4);
    check("burst_m0_acks", ack_cnt[0] - a0, 4);
    check("burst_m1_acks", ack_cnt[1] - a1, 0);
    @(negedge clk);
    check("burst_hold", gnt_o, 2'b01);
    @(negedge clk);
    check("burst_m1", gnt_o, 2'b10);
    wait_resp(1, 20, r);
    drop(1);

    // watchdog expiry with a silent slave
    slv_en = 1'b0;
    raise(0, 32'h0000_0300, 1'b0, CTI_CLASSIC, 1'b0);
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) check("to_pre", {timeout_o, err_o[0], s_stb_o}, 3'b001);
      else       check("to_fire", {timeout_o, err_o[0], s_stb_o}, 3'b110);
    end
    drop(0);
    @(negedge clk);
    check("to_once", {timeout_o, err_o[0]}, 2'b00);

    // ack landing on the expiry cycle wins
    raise(0, 32'h0000_0304, 1'b0, CTI_CLASSIC, 1'b0);
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) check("toa_pre", {timeout_o, err_o[0], s_stb_o}, 3'b001);
      if (i == 7) force_ack = 1'b1;
      if (i == 8) begin
        check("to_ack_wins", {timeout_o, ack_o[0], err_o[0], s_stb_o}, 4'b0101);
        force_ack = 1'b0;
      end
    end
    drop(0);
    slv_en = 1'b1;

    // reset in the middle of a burst
    raise(0, 32'h0000_0400, 1'b0, CTI_INCR, 1'b1);
    wait_resp(0, 20, r);
    @(posedge clk); #1; adr[0] = adr[0] + 32'd4;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0; lock[0] = 1'b0;
    @(negedge clk);
    check("mid_rst_gnt", gnt_o, 2'b00);
    check("mid_rst_cyc", s_cyc_o, 1'b0);
    check("mid_rst_ack", ack_o, 2'b00);
    raise(1, 32'h0000_0500, 1'b0, CTI_CLASSIC, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_gnt", gnt_o, 2'b10);
    wait_resp(1, 20, r);
    check("post_rst_ack", r, 3'b100);
    drop(1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Two-master to one-slave Wishbone B3 arbiter with round-robin grant and a bus-timeout watchdog.
- Shares a single slave port (bram0 or one conbus slave slot) between the lm32 instruction and data masters, or any two masters.
- Holds the grant for the full CYC_O span, so lm32 cache-line bursts (CTI=010, LOCK) are never split.

Parameters:
- TIMEOUT, 256: cycles STB may stay asserted without ACK/ERR/RTY before the arbiter terminates the access with ERR (legal range 2..65535).
- TO_W, 16: width of the watchdog counter; must satisfy TIMEOUT <= 2^TO_W - 1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- m0_adr_i, m1_adr_i  in  32  master address
- m0_dat_i, m1_dat_i  in  32  master write data
- m0_dat_o, m1_dat_o  out  32  read data (broadcast of s_dat_i)
- m0_sel_i, m1_sel_i  in  4  byte selects
- m0_we_i, m1_we_i  in  1  write enable
- m0_cyc_i, m1_cyc_i  in  1  cycle request
- m0_stb_i, m1_stb_i  in  1  strobe
- m0_cti_i, m1_cti_i  in  3  cycle type
- m0_bte_i, m1_bte_i  in  2  burst type
- m0_lock_i, m1_lock_i  in  1  lock
- m0_ack_o, m1_ack_o  out  1  acknowledge
- m0_err_o, m1_err_o  out  1  error
- m0_rty_o, m1_rty_o  out  1  retry
- s_adr_o  out  32; s_dat_o  out  32; s_dat_i  in  32; s_sel_o  out  4; s_we_o  out  1
- s_cyc_o, s_stb_o  out  1; s_cti_o  out  3; s_bte_o  out  2; s_lock_o  out  1
- s_ack_i, s_err_i, s_rty_i  in  1  slave responses
- gnt_o  out  2  one-hot current grant (00 = idle)
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: state IDLE, gnt_o=00, last=1 (so m0 wins the first tie), watchdog=0, timeout_o=0. All s_* control outputs are 0 and all m*_ack/err/rty are 0.
- States: IDLE, OWN0, OWN1. The grant is registered; the slave-side mux is combinational from the state.
- IDLE: if exactly one cyc is high, go to that master's OWN state. If both are high, grant the master that is not `last`. Otherwise stay in IDLE.
- Arbitration latency: 1 cycle from cyc rising to s_cyc_o.
- OWNx: s_* is driven from master x. mx_ack/err/rty_o follow s_*_i combinationally. The other master's ack/err/rty are forced to 0, and its requests wait.
- Leaving OWNx: when mx_cyc_i drops, set last=x. If the other master's cyc is high that same cycle, go directly to its OWN state; otherwise go to IDLE. There is no dead cycle on handover.
- Reset mid-transaction: drop s_cyc_o/s_stb_o in the next cycle and return to IDLE. No ack is forwarded.
- Watchdog:
  - The counter clears whenever the owner's stb is low, or when any of s_ack_i, s_err_i or s_rty_i is high.
  - Otherwise it increments while in an OWN state.
  - When the counter equals TIMEOUT-1 with no slave response, the arbiter asserts mx_err_o and timeout_o for exactly that cycle. It also forces s_stb_o=0 that cycle and clears the counter.
  - s_ack_i arriving in the same cycle as the timeout wins: ack is forwarded, no err, no timeout pulse.
- Slave responses while IDLE are ignored; nothing is forwarded.
- The arbiter imposes no address decode and holds no data storage. It adds no latency on the response path.

Decomposition:
- Shared package:
  - state encoding (IDLE/OWN0/OWN1)
  - Wishbone CTI constants (CLASSIC=000, INCR=010, EOB=111)
  - bus widths (ADR_W=32, DAT_W=32, SEL_W=4)
- One natural sub-module: wb_watchdog, holding the TO_W counter with clear/inc/expire logic. It is reused later by the conbus slave-timeout path.

Test Plan:
- Single master: m1 issues a classic read of 0x00000010. Expect s_cyc_o high 1 cycle after m1_cyc_i, gnt_o=10, m1_ack_o with m1_dat_o equal to the slave data, and m0_ack_o=0 throughout.
- Simultaneous request from reset: both cyc rise together. Expect m0 granted first (gnt_o=01). When m0 drops cyc, expect gnt_o=10 in the very next cycle with no IDLE cycle in between.
- Round-robin fairness: both masters hold continuous single-beat cycles for 20 transactions. Expect grants to alternate 01,10,01,... with 10 grants each (±1).
- Burst hold: m0 runs a 4-beat CTI=010 burst that ends with CTI=111 while m1 requests throughout. Expect all 4 acks to go to m0 and m1 granted only after m0_cyc_i falls.
- Timeout: TIMEOUT=8, slave never acks. Expect m0_err_o and timeout_o high for exactly 1 cycle on the 8th stb cycle, s_stb_o low that cycle, and s_ack_i arriving on cycle 8 in a rerun to produce ack with no err.
- Reset mid-burst: assert rst_i on beat 2 of a burst. Expect gnt_o=00, s_cyc_o=0 and all m*_ack_o=0 at the next edge, and a clean grant after rst_i is released.
